// File: rtl/i2s_fpga_pkg.sv
// Shared types and opcodes for the SPI command sequencer.
//   ctrl_state_t : sequencer FSM state encoding
//   OP_*         : host opcodes, the first byte of every chip-select frame
package i2s_fpga_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StLen,
        StFetch,
        StLoad,
        StStream,
        StWait,
        StRst
    } ctrl_state_t;

    localparam logic [7:0] OP_STATUS   = 8'h01;
    localparam logic [7:0] OP_READ_N   = 8'h02;
    localparam logic [7:0] OP_START    = 8'h03;
    localparam logic [7:0] OP_STOP     = 8'h04;
    localparam logic [7:0] OP_SOFT_RST = 8'hA5;

endpackage

// File: rtl/pulse_stretch.sv
// Turns a 1-cycle start strobe into a pulse exactly PULSE_LEN cycles long.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle trigger; pulse rises on the following cycle
//   pulse      : high for PULSE_LEN consecutive cycles
//   last       : high during the final cycle of the pulse
module pulse_stretch #(
    parameter int unsigned PULSE_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic pulse,
    output logic last
);

    localparam int unsigned CW = $clog2(PULSE_LEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CW'(PULSE_LEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse = (cnt_q != '0);
    assign last  = (cnt_q == CW'(1));

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between the SPI slave byte interface and the sample FIFO.
// Decodes the first byte of each chip-select frame and gates capture, returns
// a status byte, streams N FIFO bytes, or issues a soft-reset pulse.
//   clk, rst_n             : clock, asynchronous active-low reset
//   cs_active              : synchronised SPI chip select
//   rx_valid, rx_data      : received byte strobe and data
//   tx_data, tx_load       : next byte to shift out and its 1-cycle load strobe
//   fifo_rd_en             : FIFO pop, data valid one cycle later on fifo_rd_data
//   fifo_empty/full/level  : FIFO status inputs
//   capture_en             : I2S capture enable
//   soft_rst_o             : datapath soft reset, RST_PULSE cycles long
//   underrun               : sticky, stream hit an empty FIFO; cleared by STATUS
module spi_cmd_ctrl
    import i2s_fpga_pkg::*;
#(
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned RST_PULSE = 16,
    parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_active,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic [7:0]       tx_data,
    output logic             tx_load,
    output logic             fifo_rd_en,
    input  logic [7:0]       fifo_rd_data,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic [CNT_W-1:0] fifo_level,
    output logic             capture_en,
    output logic             soft_rst_o,
    output logic             underrun
);

    ctrl_state_t state_q, state_d;
    logic [8:0]  remaining_q, remaining_d;  // 9 bits so a count byte of 0 means 256
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_load_q, tx_load_d;
    logic        capture_q, capture_d;
    logic        underrun_q, underrun_d;
    logic        cs_prev_q;
    logic        rst_start, rst_last;

    pulse_stretch #(
        .PULSE_LEN(RST_PULSE)
    ) u_pulse_stretch (
        .clk  (clk),
        .rst_n(rst_n),
        .start(rst_start),
        .pulse(soft_rst_o),
        .last (rst_last)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        capture_d   = capture_q;
        underrun_d  = underrun_q;
        rst_start   = 1'b0;
        fifo_rd_en  = 1'b0;

        // Dropping cs aborts any frame except a soft reset already in flight;
        // a byte arriving in the same cycle is ignored.
        if (!cs_active && state_q != StIdle && state_q != StRst) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_active && !cs_prev_q) state_d = StCmd;
                end
                StCmd: begin
                    if (rx_valid) begin
                        state_d = StWait;
                        case (rx_data)
                            OP_STATUS: begin
                                tx_data_d  = 8'({fifo_full, fifo_empty, fifo_level});
                                tx_load_d  = 1'b1;
                                underrun_d = 1'b0;
                            end
                            OP_READ_N:   state_d = StLen;
                            OP_START:    capture_d = 1'b1;
                            OP_STOP:     capture_d = 1'b0;
                            OP_SOFT_RST: begin
                                capture_d = 1'b0;
                                rst_start = 1'b1;
                                state_d   = StRst;
                            end
                            default: ;
                        endcase
                    end
                end
                StLen: begin
                    if (rx_valid) begin
                        remaining_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        state_d     = StFetch;
                    end
                end
                StFetch: begin
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        state_d    = StLoad;
                    end else begin
                        tx_data_d  = PAD_BYTE;
                        tx_load_d  = 1'b1;
                        underrun_d = 1'b1;
                        state_d    = StStream;
                    end
                end
                StLoad: begin
                    tx_data_d = fifo_rd_data;
                    tx_load_d = 1'b1;
                    state_d   = StStream;
                end
                StStream: begin
                    if (rx_valid) begin
                        remaining_d = remaining_q - 9'd1;
                        state_d     = (remaining_q == 9'd1) ? StWait : StFetch;
                    end
                end
                StWait: ;
                StRst: begin
                    if (rst_last) state_d = StWait;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            remaining_q <= 9'd0;
            tx_data_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            capture_q   <= 1'b0;
            underrun_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            capture_q   <= capture_d;
            underrun_q  <= underrun_d;
            cs_prev_q   <= cs_active;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_load    = tx_load_q;
    assign capture_en = capture_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed command sequence with random
// FIFO contents, counts and byte gaps, checked against a frame-level model.
module tb_spi_cmd_ctrl;

    localparam int FIFO_DEPTH = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cs_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_full = 1'b0;
    logic [5:0] fifo_level = 6'd0;
    logic       capture_en;
    logic       soft_rst_o;
    logic       underrun;

    spi_cmd_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_active   (cs_active),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_level  (fifo_level),
        .capture_en  (capture_en),
        .soft_rst_o  (soft_rst_o),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] tx_got[$];
    int         tx_lat[$];
    int         cyc = 0, last_rx_cyc = 0, pops = 0, bad_pops = 0;
    int         srst_cycles = 0, srst_rises = 0;
    logic       srst_prev = 1'b0;
    int         npass = 0, ntotal = 0;
    int         model_cnt = 0;      // FIFO occupancy predicted by the model
    logic       exp_underrun = 1'b0;
    int         op, s0, r0;

    // FIFO model, tx capture and pulse monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) last_rx_cyc <= cyc;
        if (tx_load) begin
            tx_got.push_back(tx_data);
            tx_lat.push_back(cyc - last_rx_cyc);
        end
        if (fifo_rd_en) begin
            pops <= pops + 1;
            if (fifo_q.size() == 0) bad_pops <= bad_pops + 1;
            else fifo_rd_data <= fifo_q.pop_front();
        end
        if (soft_rst_o) srst_cycles <= srst_cycles + 1;
        if (soft_rst_o && !srst_prev) srst_rises <= srst_rises + 1;
        srst_prev <= soft_rst_o;
    end

    always @(negedge clk) begin
        fifo_empty <= (fifo_q.size() == 0);
        fifo_full  <= (fifo_q.size() >= FIFO_DEPTH);
        fifo_level <= 6'(fifo_q.size() >> 3);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(4 + int'($urandom_range(0, 3)));
    endtask

    task automatic cs_on();
        cs_active = 1'b1;
        tick(2);
    endtask

    task automatic cs_off();
        cs_active = 1'b0;
        tick(3);
    endtask

    function automatic logic [7:0] status_byte(input int n);
        return {n >= FIFO_DEPTH, n == 0, 6'(n >> 3)};
    endfunction

    task automatic status_case(input string tag);
        tx_got.delete();
        tx_lat.delete();
        cs_on();
        send(8'h01);
        cs_off();
        exp_underrun = 1'b0;
        chk({tag, "_cnt"}, tx_got.size(), 1);
        chk({tag, "_byte"}, (tx_got.size() > 0) ? 32'(tx_got[0]) : 32'hDEAD, status_byte(model_cnt));
        chk({tag, "_lat"}, (tx_lat.size() > 0) ? tx_lat[0] : -1, 1);
        chk({tag, "_unr"}, underrun, 0);
    endtask

    // A frame of READ_N n (0 = 256) followed by `dummies` clocking bytes.
    task automatic stream_case(input string tag, input int avail, input int n, input int dummies);
        logic [7:0] data[$];
        int eff, loads, exp_pops, p0, mism, maxlat;
        logic [7:0] e;
        data.delete();
        for (int i = 0; i < avail; i++) data.push_back(8'($urandom));
        fifo_q = data;
        tick(1);
        tx_got.delete();
        tx_lat.delete();
        p0 = pops;
        eff      = (n == 0) ? 256 : n;
        loads    = (dummies + 1 < eff) ? dummies + 1 : eff;
        exp_pops = (loads < avail) ? loads : avail;
        cs_on();
        send(8'h02);
        send(8'(n));
        for (int d = 0; d < dummies; d++) send(8'($urandom));
        cs_off();
        tick(10);
        mism = 0;
        maxlat = 0;
        for (int i = 0; i < tx_got.size(); i++) begin
            e = (i < avail) ? data[i] : 8'h00;
            if (tx_got[i] !== e) mism++;
            if (tx_lat[i] > maxlat) maxlat = tx_lat[i];
        end
        if (loads > avail) exp_underrun = 1'b1;
        model_cnt = avail - exp_pops;
        chk({tag, "_loads"}, tx_got.size(), loads);
        if (loads > 0)
            chk({tag, "_first"}, (tx_got.size() > 0) ? 32'(tx_got[0]) : 32'hDEAD,
                (avail > 0) ? 32'(data[0]) : 32'h0);
        chk({tag, "_bytes_bad"}, mism, 0);
        chk({tag, "_lat_le3"}, maxlat <= 3, 1);
        chk({tag, "_pops"}, pops - p0, exp_pops);
        chk({tag, "_unr"}, underrun, exp_underrun);
    endtask

    initial begin
        // asynchronous reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_capture", capture_en, 0);
        chk("rst_soft_rst", soft_rst_o, 0);
        chk("rst_underrun", underrun, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // START, then STOP in a later frame; capture survives cs drop
        cs_on(); send(8'h03); cs_off();
        chk("start_cap", capture_en, 1);
        cs_on(); send(8'h04); cs_off();
        chk("stop_cap", capture_en, 0);

        // unknown opcode: no response, no pops, capture untouched
        op = int'($urandom_range(5, 255));
        if (op == 8'hA5) op = 8'h77;
        tx_got.delete();
        s0 = pops;
        cs_on(); send(8'(op)); send(8'h02); send(8'h05); cs_off();
        chk("unk_tx", tx_got.size(), 0);
        chk("unk_pops", pops - s0, 0);
        chk("unk_cap", capture_en, 0);

        stream_case("rd3", 3, 3, 3);
        stream_case("rd_unr", 1, 2, 2);
        status_case("st_after_unr");

        for (int k = 0; k < 3; k++) begin
            stream_case("rd_rand", int'($urandom_range(0, 20)), int'($urandom_range(1, 12)),
                        int'($urandom_range(0, 13)));
            status_case("st_rand");
        end

        stream_case("rd256", 300, 0, 258);
        status_case("st_after256");

        // cs drops after two streamed bytes; no pops may follow
        stream_case("rd_abort", 40, 5, 2);
        s0 = pops;
        tick(20);
        chk("abort_no_pops", pops - s0, 0);
        status_case("st_after_abort");

        // soft reset with cs held, then with cs dropped mid-pulse
        cs_on(); send(8'h03); cs_off();
        chk("pre_rst_cap", capture_en, 1);
        s0 = srst_cycles; r0 = srst_rises;
        cs_on(); send(8'hA5); tick(20); cs_off();
        chk("srst_len", srst_cycles - s0, 16);
        chk("srst_once", srst_rises - r0, 1);
        chk("srst_cap", capture_en, 0);
        s0 = srst_cycles; r0 = srst_rises;
        cs_on(); send(8'hA5); cs_off(); tick(25);
        chk("srst_csdrop_len", srst_cycles - s0, 16);
        chk("srst_csdrop_once", srst_rises - r0, 1);
        status_case("st_after_srst");

        // asynchronous reset in the middle of a stream
        cs_on(); send(8'h03); cs_off();
        fifo_q.delete();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'($urandom) | 8'h01);
        tick(1);
        cs_on(); send(8'h02); send(8'd10);
        rx_data = 8'h5A;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        chk("mid_rd_en", fifo_rd_en, 1);
        chk("mid_tx_nz", tx_data != 8'h00, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_data", tx_data, 0);
        chk("arst_tx_load", tx_load, 0);
        chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_capture", capture_en, 0);
        chk("arst_soft_rst", soft_rst_o, 0);
        chk("arst_underrun", underrun, 0);
        cs_active = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        chk("never_pop_empty", bad_pops, 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
